serial_word_fifo: RTL and testbench
===================================

# serial_word_fifo

Parametrised serial-to-parallel capture buffer for the receive back end. It accumulates a bit-serial stream, such as decoded SIGNAL-field or SERVICE bits, into WIDTH-bit words, and queues completed words in a DEPTH-entry FIFO. Downstream consumers drain the FIFO through a valid/ready handshake. The block supports configurable bit order, word realignment, flush, and sticky overflow reporting.

## Interface
- WIDTH, 4, bits per assembled word (>=2)
- DEPTH, 4, FIFO entries (>=2; need not be a power of 2)
- LSB_FIRST, 1, 1: first received bit lands in bit 0; 0: first received bit lands in bit WIDTH-1
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- flush  in  1  synchronous clear of FIFO, bit counter and overflow
- bit_valid  in  1  bit_in is valid this cycle
- bit_in  in  1  serial data bit
- word_start  in  1  realign: current bit (if bit_valid) is bit 0 of a new word; any partial word is discarded
- out_valid  out  1  FIFO head valid
- out_data  out  WIDTH  FIFO head word; forced to 0 when out_valid=0
- out_ready  in  1  consumer accepts head this cycle
- count  out  $clog2(DEPTH+1)  words stored
- partial  out  1  bit counter non-zero (word in progress)
- overflow  out  1  sticky: a completed word was dropped because the FIFO was full

## Operation
- Bit counter `bcnt` runs 0..WIDTH-1 and advances on each accepted bit (bit_valid=1).
- LSB_FIRST=1: the shift register shifts right and the new bit enters the MSB. After WIDTH bits, the first bit sits in bit 0.
- LSB_FIRST=0: the shift register shifts left and the new bit enters the LSB.
- Word completion: bit_valid=1 with bcnt=WIDTH-1 (or word_start=1 with WIDTH=1, which the parameter range excludes).
  - The completed word is formed from the shift register plus bit_in and pushed on that same edge.
  - bcnt returns to 0.
- word_start=1 with bit_valid=1: bcnt is forced to 1, and the shift register holds only bit_in, placed as the first bit.
- word_start=1 with bit_valid=0: bcnt is forced to 0.
- In both word_start cases, the discarded partial word is lost silently; there is no flag.
- Push condition: word completes AND (count<DEPTH OR pop this cycle).
- Overflow: word completes, count=DEPTH, and no pop. The word is dropped and overflow is set to 1. overflow holds until reset or flush.
- Pop condition: out_valid=1 AND out_ready=1. The head advances on that edge. out_ready while empty has no effect.
- Simultaneous push and pop is legal at any fill level, including full and empty:
  - count is unchanged.
  - At count=0, the pushed word appears at the head on the following cycle.
- Read and write pointers wrap from DEPTH-1 to 0. count is maintained explicitly, not derived from pointer difference.
- Priority: reset > flush > word_start > normal operation.
- flush clears FIFO contents, pointers, count, bcnt and overflow. Any bit presented in the flush cycle is discarded.

## Timing
- All outputs are registered or derived from registers only; no combinational path from inputs to outputs.
- Reset values: out_valid=0, out_data=0, count=0, partial=0, overflow=0. The shift register and storage array are also cleared.
- Reset mid-word or with the FIFO non-empty discards everything; the first bit after reset deasserts is bit 0 of a new word.
- Latency from last bit to output: the last bit accepted at edge N gives out_valid=1 after edge N when the FIFO was empty.
- count updates on the same edge as the push or pop.
- Throughput: at most one word per WIDTH bit_valid cycles.
- Pop: one word per cycle while out_ready is held high.
- out_data is stable while out_valid=1 and out_ready=0.
- overflow rises on the edge of the dropped push.
- flush has the same one-edge effect as reset on all outputs.

## Test plan
- WIDTH=4, LSB_FIRST=1, out_ready=0; bits 1,0,1,1 on consecutive cycles -> one cycle after the 4th bit: out_valid=1, out_data=4'hD, count=1, partial=0.
- Same stimulus with LSB_FIRST=0 -> out_data=4'hB. Pop with out_ready=1 -> out_valid=0 and out_data=0 next cycle.
- DEPTH=4, out_ready=0, five words 1,2,3,4,5 -> count=4, overflow=1. Drain returns 1,2,3,4, overflow stays 1. flush -> overflow=0, count=0.
- FIFO full, out_ready=1 held, sixth word completes in the same cycle as a pop -> count stays 4, overflow=0, and the sixth word is read out last.
- Bits 1,1, then word_start with bit 0, then bits 1,0,0 -> single word 4'h2 (LSB_FIRST=1). The partial 1,1 never appears.
- Two bits accepted and two words queued, then reset for one cycle -> all outputs 0. Bits 1,1,1,1 after reset -> out_data=4'hF, count=1.

Source files
------------

// File: rtl/serial_word_fifo_if.sv
// Handshake bundle for serial_word_fifo: serial bit input, FIFO drain port and status.
// The slave modport is the FIFO itself; the master modport is the bit source and consumer.
interface serial_word_fifo_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 4
);
    logic                           flush;
    logic                           bit_valid;
    logic                           bit_in;
    logic                           word_start;
    logic                           out_valid;
    logic [WIDTH-1:0]               out_data;
    logic                           out_ready;
    logic [$clog2(DEPTH+1)-1:0]     count;
    logic                           partial;
    logic                           overflow;

    modport master (
        output flush, bit_valid, bit_in, word_start, out_ready,
        input  out_valid, out_data, count, partial, overflow
    );

    modport slave (
        input  flush, bit_valid, bit_in, word_start, out_ready,
        output out_valid, out_data, count, partial, overflow
    );
endinterface

// File: rtl/serial_word_fifo.sv
// Serial-to-parallel word assembler feeding a DEPTH-entry FIFO with valid/ready drain,
// word realignment, flush and sticky overflow.
module serial_word_fifo #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned DEPTH     = 4,
    parameter bit          LSB_FIRST = 1'b1
) (
    input logic              clk,
    input logic              reset,
    serial_word_fifo_if.slave bus_io
);
    localparam int unsigned CntW  = $clog2(DEPTH + 1);
    localparam int unsigned PtrW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned BcntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [BcntW-1:0] bcnt_q, bcnt_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wptr_q, wptr_d;
    logic [PtrW-1:0]  rptr_q, rptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             overflow_q, overflow_d;

    logic [WIDTH-1:0] sreg_shift;
    logic [WIDTH-1:0] sreg_first;
    logic             complete;
    logic             pop;
    logic             push;
    logic             full;

    always_comb begin
        if (LSB_FIRST) begin
            sreg_shift = {bus_io.bit_in, sreg_q[WIDTH-1:1]};
            sreg_first = {bus_io.bit_in, {(WIDTH-1){1'b0}}};
        end else begin
            sreg_shift = {sreg_q[WIDTH-2:0], bus_io.bit_in};
            sreg_first = {{(WIDTH-1){1'b0}}, bus_io.bit_in};
        end
    end

    // A realigning bit is always bit 0 of a new word, so it can never complete one.
    assign full     = (count_q == CntW'(DEPTH));
    assign complete = bus_io.bit_valid && !bus_io.word_start && (bcnt_q == BcntW'(WIDTH - 1));
    assign pop      = (count_q != '0) && bus_io.out_ready;
    assign push     = complete && (!full || pop);

    always_comb begin
        sreg_d     = sreg_q;
        bcnt_d     = bcnt_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (bus_io.word_start) begin
            bcnt_d = bus_io.bit_valid ? BcntW'(1) : '0;
            sreg_d = bus_io.bit_valid ? sreg_first : '0;
        end else if (bus_io.bit_valid) begin
            sreg_d = sreg_shift;
            bcnt_d = complete ? '0 : bcnt_q + BcntW'(1);
        end

        if (push) begin
            wptr_d = (wptr_q == PtrW'(DEPTH - 1)) ? '0 : wptr_q + PtrW'(1);
        end
        if (pop) begin
            rptr_d = (rptr_q == PtrW'(DEPTH - 1)) ? '0 : rptr_q + PtrW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CntW'(1);
        end
        if (complete && full && !pop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || bus_io.flush) begin
            sreg_q     <= '0;
            bcnt_q     <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            sreg_q     <= sreg_d;
            bcnt_q     <= bcnt_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            if (push) begin
                mem_q[wptr_q] <= sreg_shift;
            end
        end
    end

    // Head is gated to zero when empty; everything here comes from registers only.
    assign bus_io.out_valid = (count_q != '0);
    assign bus_io.out_data  = (count_q != '0) ? mem_q[rptr_q] : '0;
    assign bus_io.count     = count_q;
    assign bus_io.partial   = (bcnt_q != '0);
    assign bus_io.overflow  = overflow_q;
endmodule

// File: tb/tb_serial_word_fifo.sv
// Directed bench: one LSB-first and one MSB-first instance share identical stimulus.
module tb_serial_word_fifo;
    logic clk;
    logic reset;
    int   n_assert;
    int   n_fail;

    serial_word_fifo_if #(.WIDTH(4), .DEPTH(4)) bus_l ();
    serial_word_fifo_if #(.WIDTH(4), .DEPTH(4)) bus_m ();

    serial_word_fifo #(.WIDTH(4), .DEPTH(4), .LSB_FIRST(1'b1)) dut_l (
        .clk    (clk),
        .reset  (reset),
        .bus_io (bus_l.slave)
    );

    serial_word_fifo #(.WIDTH(4), .DEPTH(4), .LSB_FIRST(1'b0)) dut_m (
        .clk    (clk),
        .reset  (reset),
        .bus_io (bus_m.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs to both instances, then sample 1 time unit after the edge.
    task automatic cyc(input logic bv, input logic b, input logic ws, input logic rdy,
                       input logic fl);
        bus_l.bit_valid = bv;  bus_m.bit_valid = bv;
        bus_l.bit_in = b;      bus_m.bit_in = b;
        bus_l.word_start = ws; bus_m.word_start = ws;
        bus_l.out_ready = rdy; bus_m.out_ready = rdy;
        bus_l.flush = fl;      bus_m.flush = fl;
        @(posedge clk);
        #1;
    endtask

    // LSB-first word: bit 0 of v is sent first.
    task automatic send_word(input logic [3:0] v, input logic rdy);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, v[i], 1'b0, rdy, 1'b0);
        end
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        reset    = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;

        chk("rst_out_valid", bus_l.out_valid, 1'b0);
        chk("rst_out_data", bus_l.out_data, 4'h0);
        chk("rst_count", bus_l.count, 3'd0);
        chk("rst_partial", bus_l.partial, 1'b0);
        chk("rst_overflow", bus_l.overflow, 1'b0);

        // Bits 1,0,1,1: LSB-first gives D, MSB-first gives B.
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("partial_mid_word", bus_l.partial, 1'b1);
        chk("no_valid_mid_word", bus_l.out_valid, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("w1_valid", bus_l.out_valid, 1'b1);
        chk("w1_data_lsb", bus_l.out_data, 4'hD);
        chk("w1_data_msb", bus_m.out_data, 4'hB);
        chk("w1_count", bus_l.count, 3'd1);
        chk("w1_partial", bus_l.partial, 1'b0);

        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("pop_valid", bus_m.out_valid, 1'b0);
        chk("pop_data", bus_m.out_data, 4'h0);
        chk("pop_count", bus_l.count, 3'd0);

        // Five words into a 4-deep FIFO: fifth is dropped.
        for (int w = 1; w <= 5; w++) begin
            send_word(4'(w), 1'b0);
        end
        chk("ovf_count", bus_l.count, 3'd4);
        chk("ovf_flag", bus_l.overflow, 1'b1);
        for (int w = 1; w <= 4; w++) begin
            chk($sformatf("drain_%0d", w), bus_l.out_data, 32'(w));
            cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        chk("drained_valid", bus_l.out_valid, 1'b0);
        chk("ovf_sticky", bus_l.overflow, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("flush_overflow", bus_l.overflow, 1'b0);
        chk("flush_count", bus_l.count, 3'd0);

        // Full FIFO, sixth word completes together with a pop.
        for (int w = 6; w <= 9; w++) begin
            send_word(4'(w), 1'b0);
        end
        chk("full_count", bus_l.count, 3'd4);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("pushpop_count", bus_l.count, 3'd4);
        chk("pushpop_overflow", bus_l.overflow, 1'b0);
        for (int w = 7; w <= 10; w++) begin
            chk($sformatf("pushpop_drain_%0d", w), bus_l.out_data, 32'(w));
            cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        chk("pushpop_empty", bus_l.count, 3'd0);

        // Realign: 1,1 discarded; word is 0,1,0,0.
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("realign_partial", bus_l.partial, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("realign_not_yet", bus_l.count, 3'd0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("realign_count", bus_l.count, 3'd1);
        chk("realign_data_lsb", bus_l.out_data, 4'h2);
        chk("realign_data_msb", bus_m.out_data, 4'h4);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Two words queued plus two bits, then reset.
        send_word(4'h3, 1'b0);
        send_word(4'h5, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("pre_rst_count", bus_l.count, 3'd2);
        chk("pre_rst_partial", bus_l.partial, 1'b1);
        reset = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        chk("mid_rst_valid", bus_l.out_valid, 1'b0);
        chk("mid_rst_data", bus_l.out_data, 4'h0);
        chk("mid_rst_count", bus_l.count, 3'd0);
        chk("mid_rst_partial", bus_l.partial, 1'b0);
        send_word(4'hF, 1'b0);
        chk("post_rst_data", bus_l.out_data, 4'hF);
        chk("post_rst_count", bus_l.count, 3'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
